// File: rtl/xnor_pkg.sv
// rtl/xnor_pkg.sv - shared helpers for the xnor match pipeline and its reference models
package xnor_pkg;

  // Widest operand the reference popcount accepts; callers zero-extend narrower vectors.
  localparam int MAX_W = 64;

  // Width needed to hold a count of 0..width.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

  // Behavioural popcount for reference modelling.
  function automatic int popcount(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/xnor_match_pipe_popcount_tree.sv
// rtl/xnor_match_pipe_popcount_tree.sv - combinational popcount as a recursive adder tree
module popcount_tree #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    cnt
);

  generate
    if (WIDTH == 1) begin : g_leaf
      // A single bit is its own count.
      assign cnt = CW'(bits);
    end else begin : g_node
      localparam int LW  = WIDTH / 2;
      localparam int HW  = WIDTH - LW;
      localparam int LCW = $clog2(LW + 1);
      localparam int HCW = $clog2(HW + 1);

      logic [LCW-1:0] lo_cnt;
      logic [HCW-1:0] hi_cnt;

      popcount_tree #(.WIDTH(LW), .CW(LCW)) u_lo (
        .bits (bits[LW-1:0]),
        .cnt  (lo_cnt)
      );

      popcount_tree #(.WIDTH(HW), .CW(HCW)) u_hi (
        .bits (bits[WIDTH-1:LW]),
        .cnt  (hi_cnt)
      );

      // Each half count fits in CW, and so does their sum (at most WIDTH).
      assign cnt = CW'(lo_cnt) + CW'(hi_cnt);
    end
  endgenerate

endmodule

// File: rtl/xnor_match_pipe.sv
// rtl/xnor_match_pipe.sv - two-stage registered XNOR similarity / equality checker
module xnor_match_pipe
  import xnor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RUN_W = 8,
  parameter int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    thresh,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             eq,
  output logic [CW-1:0]    match_cnt,
  output logic             above_thr,
  output logic [RUN_W-1:0] run_len
);

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  logic             v1;
  logic [WIDTH-1:0] y1;
  logic [CW-1:0]    thresh1;
  logic [CW-1:0]    cnt1;
  logic             eq1;

  popcount_tree #(.WIDTH(WIDTH), .CW(CW)) u_popcount (
    .bits (y1),
    .cnt  (cnt1)
  );

  assign eq1 = &y1;

  // Stage 1: capture the per-bit match vector and its threshold; valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      y1      <= '0;
      thresh1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        y1      <= a ~^ b;
        thresh1 <= thresh;
      end
    end
  end

  // Stage 2: count, compare and register results; outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      eq        <= 1'b0;
      match_cnt <= '0;
      above_thr <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        y         <= y1;
        eq        <= eq1;
        match_cnt <= cnt1;
        above_thr <= (cnt1 >= thresh1);
      end
    end
  end

  // Saturating run of consecutive equal samples; bubbles neither extend nor break it.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len <= '0;
    end else if (v1) begin
      if (!eq1) begin
        run_len <= '0;
      end else if (run_len != RUN_MAX) begin
        run_len <= run_len + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xnor_match_pipe.sv
// tb/tb_xnor_match_pipe.sv - directed self-checking bench for xnor_match_pipe
module tb_xnor_match_pipe;

  localparam int WIDTH = 8;
  localparam int RUN_W = 2;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [CW-1:0]    thresh = '0;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             eq;
  logic [CW-1:0]    match_cnt;
  logic             above_thr;
  logic [RUN_W-1:0] run_len;

  int total = 0;
  int bad = 0;

  xnor_match_pipe #(.WIDTH(WIDTH), .RUN_W(RUN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .thresh    (thresh),
    .out_valid (out_valid),
    .y         (y),
    .eq        (eq),
    .match_cnt (match_cnt),
    .above_thr (above_thr),
    .run_len   (run_len)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic [3:0] t);
    in_valid = v;
    a        = av;
    b        = bv;
    thresh   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 8'h00, 4'd0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 8'hFF, 4'd8);
      got = {out_valid, y, eq, match_cnt, above_thr, run_len};
      total++;
      if (got !== 17'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got=%h exp=%h", i, got, 17'h0);
      end
    end
    rst = 1'b0;
    step(1'b1, 8'hFF, 8'hFF, 4'd8);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ov1 got=%b exp=0", out_valid);
    end
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if (out_valid !== 1'b1 || run_len !== 2'd1) begin
      bad++;
      $display("FAIL reset_release_ov2 got ov=%b run=%0d exp ov=1 run=1", out_valid, run_len);
    end
  endtask

  task automatic test_equality();
    do_reset();
    step(1'b1, 8'hA5, 8'hA5, 4'd8);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL eq_latency_early got=%b exp=0", out_valid);
    end
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if ({out_valid, y, eq, match_cnt, above_thr, run_len} !== {1'b1, 8'hFF, 1'b1, 4'd8, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL eq_result got ov=%b y=%h eq=%b cnt=%0d thr=%b run=%0d exp ov=1 y=ff eq=1 cnt=8 thr=1 run=1",
               out_valid, y, eq, match_cnt, above_thr, run_len);
    end
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if (out_valid !== 1'b0 || y !== 8'hFF) begin
      bad++;
      $display("FAIL eq_hold got ov=%b y=%h exp ov=0 y=ff", out_valid, y);
    end
  endtask

  task automatic test_partial();
    step(1'b1, 8'hF0, 8'h0F, 4'd1);
    step(1'b1, 8'hF0, 8'hF3, 4'd6);
    total++;
    if ({out_valid, y, eq, match_cnt, above_thr, run_len} !== {1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL partial_none got ov=%b y=%h eq=%b cnt=%0d thr=%b run=%0d exp ov=1 y=00 eq=0 cnt=0 thr=0 run=0",
               out_valid, y, eq, match_cnt, above_thr, run_len);
    end
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if ({out_valid, y, eq, match_cnt, above_thr, run_len} !== {1'b1, 8'hFC, 1'b0, 4'd6, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL partial_six got ov=%b y=%h eq=%b cnt=%0d thr=%b run=%0d exp ov=1 y=fc eq=0 cnt=6 thr=1 run=0",
               out_valid, y, eq, match_cnt, above_thr, run_len);
    end
  endtask

  task automatic test_run_saturation();
    logic       vin [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] bin [8] = '{8'h5A, 8'h5A, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h00};
    logic       eov [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] erun[8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vin[i], 8'h5A, bin[i], 4'd8);
      if (i >= 1) begin
        total++;
        if (out_valid !== eov[i] || run_len !== erun[i]) begin
          bad++;
          $display("FAIL run_step%0d got ov=%b run=%0d exp ov=%b run=%0d", i, out_valid, run_len, eov[i], erun[i]);
        end
      end
    end
  endtask

  task automatic test_thresh_bounds();
    step(1'b1, 8'h00, 8'hFF, 4'd0);
    step(1'b1, 8'h5A, 8'h5A, 4'd9);
    total++;
    if (above_thr !== 1'b1 || match_cnt !== 4'd0) begin
      bad++;
      $display("FAIL thresh_zero got thr=%b cnt=%0d exp thr=1 cnt=0", above_thr, match_cnt);
    end
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if (above_thr !== 1'b0 || eq !== 1'b1 || match_cnt !== 4'd8) begin
      bad++;
      $display("FAIL thresh_nine got thr=%b eq=%b cnt=%0d exp thr=0 eq=1 cnt=8", above_thr, eq, match_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 8'h3C, 8'h3C, 4'd4);
    step(1'b1, 8'h3C, 8'h3C, 4'd4);
    total++;
    if (out_valid !== 1'b1 || run_len !== 2'd1) begin
      bad++;
      $display("FAIL midrst_first got ov=%b run=%0d exp ov=1 run=1", out_valid, run_len);
    end
    rst = 1'b1;
    step(1'b1, 8'h3C, 8'h3C, 4'd4);
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || run_len !== 2'd0) begin
      bad++;
      $display("FAIL midrst_flush got ov=%b run=%0d exp ov=0 run=0", out_valid, run_len);
    end
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_discard got ov=%b exp=0", out_valid);
    end
    step(1'b1, 8'h3C, 8'h3C, 4'd4);
    step(1'b0, 8'h00, 8'h00, 4'd0);
    total++;
    if (out_valid !== 1'b1 || run_len !== 2'd1) begin
      bad++;
      $display("FAIL midrst_restart got ov=%b run=%0d exp ov=1 run=1", out_valid, run_len);
    end
  endtask

  initial begin
    test_reset();
    test_equality();
    test_partial();
    test_run_saturation();
    test_thresh_bounds();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
